mic_emi_arb: RTL and testbench

- N-port arbiter/bridge between CPU-side EMI requesters (I-cache, D-cache, MMU walker, DMA) and the control side of one mic_m_if master interface.
- Generalises the two-port fixed-priority CPU bridge: parametrised port count, cache-line beat count, and fixed-priority or round-robin arbitration.
- Serves one transaction at a time, issues one req_start pulse per grant, and routes beat handshakes back to the granted port.

---
 rtl/mic_emi_arb.sv | 202 ++++++++++++++++++++
 tb/tb_mic_emi_arb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mic_emi_arb.sv
// mic_emi_arb: N-port arbiter/bridge from CPU-side EMI requesters onto the
// control side of one mic_m_if master interface. Only one transaction is in
// flight at a time. Each grant produces a single req_start pulse, and beat
// handshakes are routed back to the granted port.
//
// Parameters: NUM_PORTS (1..8), CL_BEATS (beats per cache line),
//             ARB_MODE (0 = fixed priority, 1 = round-robin).
// Ports:
//   clk, reset (sync, active-high)
//   emi_*      per-port request side (addr/wdata/size/RnW/req in, rdata/valid out)
//   req_*      mic_m_if request channel
//   read_*     mic_m_if read data channel
//   write_*    mic_m_if write data channel
//   stat_grants  per-port completed-transaction counters; this port exists
//                only when MIC_EMI_ARB_STATS_EN is defined
module mic_emi_arb #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned CL_BEATS  = 4,
  parameter int unsigned ARB_MODE  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORTS*32-1:0] emi_addr,
  input  logic [NUM_PORTS*64-1:0] emi_wdata,
  input  logic [NUM_PORTS*2-1:0]  emi_size,
  input  logic [NUM_PORTS-1:0]    emi_RnW,
  input  logic [NUM_PORTS-1:0]    emi_req,
  output logic [63:0]             emi_rdata,
  output logic [NUM_PORTS-1:0]    emi_valid,
  input  logic                   req_ready,
  output logic                   req_start,
  output logic                   req_RnW,
  output logic [7:0]             req_beats,
  output logic [28:0]            req_address,
  output logic [4:0]             req_byte_enables,
  input  logic [63:0]            read_data,
  input  logic                   read_data_valid,
  output logic                   read_data_ready,
  output logic [63:0]            write_data,
  output logic                   write_data_valid,
`ifdef MIC_EMI_ARB_STATS_EN
  output logic [NUM_PORTS*16-1:0] stat_grants,
`endif
  input  logic                   write_data_ready
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [7:0] CL_LAST = 8'(CL_BEATS - 1);
  localparam logic [IDX_W-1:0] RR_INIT = IDX_W'(NUM_PORTS - 1);

  typedef enum logic {IDLE, XFER} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  req_start_q, req_start_d;

  logic [IDX_W-1:0]      pick;
  logic                  arb_found;
  int unsigned           arb_idx;
  logic [NUM_PORTS-1:0]  req_sh;
  logic                  beat;

  logic [31:0]           g_addr;
  logic [63:0]           g_wdata;
  logic [1:0]            g_size;
  logic                  g_rnw;
  logic [1:0]            pick_size;

`ifdef MIC_EMI_ARB_STATS_EN
  logic [NUM_PORTS-1:0][15:0] stat_q, stat_d;
  assign stat_grants = stat_q;
`endif

  assign req_start       = req_start_q;
  assign read_data_ready = 1'b1;

  // Arbiter. Fixed mode scans upward from port 0.
  // Round-robin mode scans upward starting at ptr+1 and wraps modulo NUM_PORTS.
  always_comb begin
    arb_found = 1'b0;
    pick      = '0;
    arb_idx   = 0;
    req_sh    = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (ARB_MODE == 1) arb_idx = (32'(ptr_q) + k + 1) % NUM_PORTS;
      else               arb_idx = k;
      req_sh = emi_req >> arb_idx;
      if (!arb_found && req_sh[0]) begin
        arb_found = 1'b1;
        pick      = IDX_W'(arb_idx);
      end
    end
  end

  // Select the granted port's request fields and the candidate port's size.
  always_comb begin
    g_addr    = '0;
    g_wdata   = '0;
    g_size    = '0;
    g_rnw     = 1'b1;
    pick_size = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (grant_q == IDX_W'(p)) begin
        g_addr  = emi_addr[p*32 +: 32];
        g_wdata = emi_wdata[p*64 +: 64];
        g_size  = emi_size[p*2 +: 2];
        g_rnw   = emi_RnW[p];
      end
      if (pick == IDX_W'(p)) pick_size = emi_size[p*2 +: 2];
    end
  end

  // Next-state logic and the combinational XFER outputs.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    ptr_d            = ptr_q;
    cnt_d            = cnt_q;
    req_start_d      = 1'b0;
    beat             = 1'b0;
    req_RnW          = 1'b1;
    req_beats        = 8'h00;
    req_address      = '0;
    req_byte_enables = 5'h1f;
    write_data       = '0;
    write_data_valid = 1'b0;
    emi_rdata        = '0;
    emi_valid        = '0;
`ifdef MIC_EMI_ARB_STATS_EN
    stat_d           = stat_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_ready && arb_found) begin
          state_d     = XFER;
          grant_d     = pick;
          req_start_d = 1'b1;
          cnt_d       = (pick_size == 2'b11) ? CL_LAST : 8'h00;
          if (ARB_MODE == 1) ptr_d = pick;
        end
      end
      XFER: begin
        req_RnW          = g_rnw;
        req_address      = g_addr[31:3];
        req_beats        = (g_size == 2'b11) ? CL_LAST : 8'h00;
        write_data       = g_wdata;
        write_data_valid = ~g_rnw;
        emi_rdata        = read_data;
        case (g_size)
          2'b11:   req_byte_enables = 5'h1f;
          2'b10:   req_byte_enables = {2'b10, g_addr[2], 2'b00};
          2'b01:   req_byte_enables = {2'b01, g_addr[2:1], 1'b0};
          default: req_byte_enables = {2'b00, g_addr[2:0]};
        endcase
        // Suppress beat strobes during the reset cycle itself.
        beat = (g_rnw ? read_data_valid : write_data_ready) & ~reset;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
          emi_valid[p] = beat && (grant_q == IDX_W'(p));
        end
        if (beat) begin
          if (cnt_q != 8'h00) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d = IDLE;
`ifdef MIC_EMI_ARB_STATS_EN
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
              if (grant_q == IDX_W'(p)) stat_d[p] = stat_q[p] + 16'd1;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= RR_INIT;
      cnt_q       <= 8'h00;
      req_start_q <= 1'b0;
`ifdef MIC_EMI_ARB_STATS_EN
      stat_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      req_start_q <= req_start_d;
`ifdef MIC_EMI_ARB_STATS_EN
      stat_q      <= stat_d;
`endif
    end
  end

endmodule

// File: tb/tb_mic_emi_arb.sv
// Directed bench for mic_emi_arb. It drives a 2-port fixed-priority instance
// and a 3-port round-robin instance. Expected values are hand-computed.
module tb_mic_emi_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;

  // 2-port fixed priority instance
  logic [63:0]  emi_addr;
  logic [127:0] emi_wdata;
  logic [3:0]   emi_size;
  logic [1:0]   emi_RnW, emi_req, emi_valid;
  logic [63:0]  emi_rdata;
  logic         req_ready, req_start, req_RnW;
  logic [7:0]   req_beats;
  logic [28:0]  req_address;
  logic [4:0]   req_byte_enables;
  logic [63:0]  read_data, write_data;
  logic         read_data_valid, read_data_ready, write_data_valid, write_data_ready;
`ifdef MIC_EMI_ARB_STATS_EN
  logic [31:0]  stat_grants;
  logic [47:0]  stat_grants_3;
`endif

  // 3-port round-robin instance
  logic [95:0]  emi_addr_3;
  logic [191:0] emi_wdata_3;
  logic [5:0]   emi_size_3;
  logic [2:0]   emi_RnW_3, emi_req_3, emi_valid_3;
  logic [63:0]  emi_rdata_3;
  logic         req_ready_3, req_start_3, req_RnW_3;
  logic [7:0]   req_beats_3;
  logic [28:0]  req_address_3;
  logic [4:0]   req_byte_enables_3;
  logic [63:0]  write_data_3;
  logic         read_data_valid_3, read_data_ready_3, write_data_valid_3;

  mic_emi_arb #(.NUM_PORTS(2), .CL_BEATS(4), .ARB_MODE(0)) dut (
    .clk(clk), .reset(reset),
    .emi_addr(emi_addr), .emi_wdata(emi_wdata), .emi_size(emi_size),
    .emi_RnW(emi_RnW), .emi_req(emi_req), .emi_rdata(emi_rdata), .emi_valid(emi_valid),
    .req_ready(req_ready), .req_start(req_start), .req_RnW(req_RnW),
    .req_beats(req_beats), .req_address(req_address), .req_byte_enables(req_byte_enables),
    .read_data(read_data), .read_data_valid(read_data_valid), .read_data_ready(read_data_ready),
    .write_data(write_data), .write_data_valid(write_data_valid),
`ifdef MIC_EMI_ARB_STATS_EN
    .stat_grants(stat_grants),
`endif
    .write_data_ready(write_data_ready)
  );

  mic_emi_arb #(.NUM_PORTS(3), .CL_BEATS(4), .ARB_MODE(1)) dut_rr (
    .clk(clk), .reset(reset),
    .emi_addr(emi_addr_3), .emi_wdata(emi_wdata_3), .emi_size(emi_size_3),
    .emi_RnW(emi_RnW_3), .emi_req(emi_req_3), .emi_rdata(emi_rdata_3), .emi_valid(emi_valid_3),
    .req_ready(req_ready_3), .req_start(req_start_3), .req_RnW(req_RnW_3),
    .req_beats(req_beats_3), .req_address(req_address_3), .req_byte_enables(req_byte_enables_3),
    .read_data(read_data), .read_data_valid(read_data_valid_3), .read_data_ready(read_data_ready_3),
    .write_data(write_data_3), .write_data_valid(write_data_valid_3),
`ifdef MIC_EMI_ARB_STATS_EN
    .stat_grants(stat_grants_3),
`endif
    .write_data_ready(1'b0)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] rr_exp [4];
  int         waited;

  initial begin
    reset = 1'b1;
    emi_addr = '0; emi_wdata = '0; emi_size = '0; emi_RnW = '1; emi_req = '0;
    req_ready = 1'b0; read_data = '0; read_data_valid = 1'b0; write_data_ready = 1'b0;
    emi_addr_3 = '0; emi_wdata_3 = '0; emi_size_3 = '0; emi_RnW_3 = '1; emi_req_3 = '0;
    req_ready_3 = 1'b0; read_data_valid_3 = 1'b0;
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

    repeat (3) step();
    reset = 1'b0;
    #1;
    check("rst_start", req_start, 0);
    check("rst_valid", emi_valid, 0);
    check("rst_be", req_byte_enables, 5'h1f);
    check("rst_rnw", req_RnW, 1);
    check("rst_rdready", read_data_ready, 1);

    // A request is ignored while req_ready is low.
    emi_req = 2'b01;
    step(); step();
    check("noready_start", req_start, 0);

    // Reset arrives after 2 beats of a 4-beat read; the next grant reloads the beat count.
    emi_addr[31:0] = 32'h100; emi_size[1:0] = 2'b11; emi_RnW[0] = 1'b1; req_ready = 1'b1;
    step();
    check("rst5_start", req_start, 1);
    check("rst5_beats", req_beats, 3);
    read_data = 64'hDEAD; read_data_valid = 1'b1;
    #1;
    check("rst5_beat0", emi_valid, 2'b01);
    check("rst5_rdata", emi_rdata, 64'hDEAD);
    step();
    check("rst5_beat1", emi_valid, 2'b01);
    step();
    reset = 1'b1; read_data_valid = 1'b0;
    step();
    reset = 1'b0; read_data_valid = 1'b1;
    #1;
    check("rst5_idle_valid", emi_valid, 0);
    check("rst5_idle_start", req_start, 0);
    step();
    check("rst5_regrant", req_start, 1);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("rst5_reload_beat%0d", b), emi_valid, 2'b01);
      if (b == 3) emi_req = 2'b00;
      step();
    end
    check("rst5_done_valid", emi_valid, 0);
    check("rst5_done_start", req_start, 0);
    read_data_valid = 1'b0;

    // Port 1 performs a 32-bit read at 0x1004 while port 0 is idle.
    emi_addr[63:32] = 32'h1004; emi_size[3:2] = 2'b10; emi_RnW[1] = 1'b1; emi_req = 2'b10;
    step();
    check("t1_start", req_start, 1);
    check("t1_beats", req_beats, 0);
    check("t1_addr", req_address, 29'h200);
    check("t1_be", req_byte_enables, 5'h14);
    check("t1_rnw", req_RnW, 1);
    check("t1_wait_valid", emi_valid, 0);
    read_data = 64'h0123456789abcdef; read_data_valid = 1'b1;
    #1;
    check("t1_valid", emi_valid, 2'b10);
    check("t1_rdata", emi_rdata, 64'h0123456789abcdef);
    emi_req = 2'b00;
    step();
    check("t1_idle_valid", emi_valid, 0);
    check("t1_idle_rdata", emi_rdata, 0);
    read_data_valid = 1'b0;

    // Both ports request a cache line; port 0 is served first, then port 1.
    emi_addr[31:0] = 32'h100; emi_addr[63:32] = 32'h200; emi_size = 4'b1111;
    emi_RnW = 2'b11; emi_req = 2'b11;
    step();
    check("t2_start0", req_start, 1);
    check("t2_beats0", req_beats, 3);
    check("t2_addr0", req_address, 29'h20);
    read_data_valid = 1'b1;
    #1;
    for (int b = 0; b < 4; b++) begin
      check($sformatf("t2_p0_beat%0d", b), emi_valid, 2'b01);
      if (b == 3) emi_req = 2'b10;
      step();
    end
    check("t2_gap_start", req_start, 0);
    check("t2_gap_valid", emi_valid, 0);
    step();
    check("t2_start1", req_start, 1);
    check("t2_addr1", req_address, 29'h40);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("t2_p1_beat%0d", b), emi_valid, 2'b10);
      if (b == 3) emi_req = 2'b00;
      step();
    end
    read_data_valid = 1'b0;
    #1;
    check("t2_end_valid", emi_valid, 0);

    // Port 0 performs a byte write at 0x7; write_data_ready arrives 3 cycles late.
    emi_addr[31:0] = 32'h7; emi_wdata[63:0] = 64'hAB; emi_size[1:0] = 2'b00;
    emi_RnW[0] = 1'b0; emi_req = 2'b01;
    step();
    check("t4_start", req_start, 1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t4_rnw%0d", c), req_RnW, 0);
      check($sformatf("t4_be%0d", c), req_byte_enables, 5'h07);
      check($sformatf("t4_wdata%0d", c), write_data, 64'hAB);
      check($sformatf("t4_wdv%0d", c), write_data_valid, 1);
      check($sformatf("t4_novalid%0d", c), emi_valid, 0);
      step();
    end
    write_data_ready = 1'b1;
    #1;
    check("t4_valid", emi_valid, 2'b01);
    check("t4_wdv_last", write_data_valid, 1);
    emi_req = 2'b00;
    step();
    check("t4_idle_wdv", write_data_valid, 0);
    check("t4_idle_valid", emi_valid, 0);
    write_data_ready = 1'b0;

`ifdef MIC_EMI_ARB_STATS_EN
    check("stat_grants", stat_grants, {16'd2, 16'd3});
`endif

    // Three-port round-robin with every port requesting continuously.
    emi_req_3 = 3'b111; req_ready_3 = 1'b1; read_data_valid_3 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      waited = 0;
      while (!req_start_3 && waited < 10) begin
        step();
        waited++;
      end
      check($sformatf("rr_start%0d", g), req_start_3, 1);
      check($sformatf("rr_grant%0d", g), emi_valid_3, rr_exp[g]);
      step();
    end
    emi_req_3 = '0; read_data_valid_3 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
